// File: rtl/data_out_encoder.sv
// data_out_encoder: serialises 32-bit words into four lane-tagged bytes.
// A one-word pending buffer lets the next word be accepted while the
// current one is still being sent, so the byte bus never idles between words.
module data_out_encoder #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [7:0]  byte_out,
    output logic [1:0]  byte_sel,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        word_done,
    output logic        busy
);

    localparam logic [1:0] FIRST_LANE = LSB_FIRST ? 2'd0 : 2'd3;
    localparam logic [1:0] LAST_LANE  = LSB_FIRST ? 2'd3 : 2'd0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [31:0] act_word, act_next;
    logic [31:0] pend_word, pend_next;
    logic        pend_valid, pend_valid_next;
    logic [1:0]  idx, idx_next;
    logic        done_next;
    logic        wacc;
    logic        bxfer;
    logic        last_lane;
    logic [1:0]  idx_step;

    // Outputs are forced quiet while reset is held so nothing leaks downstream.
    assign word_ready = rst_n & ((state == IDLE) | ~pend_valid);
    assign byte_valid = rst_n & (state == SEND);
    assign busy       = rst_n & ((state == SEND) | pend_valid);
    assign byte_sel   = rst_n ? idx : 2'd0;
    assign byte_out   = (rst_n && (state == SEND)) ? act_word[{idx, 3'b000} +: 8] : 8'd0;

    assign wacc      = word_valid & word_ready;
    assign bxfer     = byte_valid & byte_ready;
    assign last_lane = (idx == LAST_LANE);
    assign idx_step  = LSB_FIRST ? (idx + 2'd1) : (idx - 2'd1);

    // Next-state logic: completion of the last lane hands over to the pending
    // word first, then to a word arriving this cycle, otherwise goes idle.
    always_comb begin
        state_next      = state;
        act_next        = act_word;
        pend_next       = pend_word;
        pend_valid_next = pend_valid;
        idx_next        = idx;
        done_next       = 1'b0;
        case (state)
            IDLE: begin
                if (wacc) begin
                    act_next   = word_in;
                    idx_next   = FIRST_LANE;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (bxfer && last_lane) begin
                    done_next = 1'b1;
                    if (pend_valid) begin
                        act_next = pend_word;
                        idx_next = FIRST_LANE;
                        if (wacc) begin
                            pend_next = word_in;
                        end else begin
                            pend_valid_next = 1'b0;
                        end
                    end else if (wacc) begin
                        act_next = word_in;
                        idx_next = FIRST_LANE;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (bxfer) begin
                        idx_next = idx_step;
                    end
                    if (wacc) begin
                        pend_next       = word_in;
                        pend_valid_next = 1'b1;
                    end
                end
            end
        endcase
    end

    // State register with synchronous active-low reset that drops all words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            act_word   <= 32'd0;
            pend_word  <= 32'd0;
            pend_valid <= 1'b0;
            idx        <= FIRST_LANE;
            word_done  <= 1'b0;
        end else begin
            state      <= state_next;
            act_word   <= act_next;
            pend_word  <= pend_next;
            pend_valid <= pend_valid_next;
            idx        <= idx_next;
            word_done  <= done_next;
        end
    end

endmodule

// File: tb/tb_data_out_encoder.sv
// Testbench for data_out_encoder: drives an LSB-first and an MSB-first
// instance with shared stimulus and compares both against a word-queue model.
module tb_data_out_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] word_in;
    logic        word_valid;
    logic        byte_ready;

    logic        word_ready_a, byte_valid_a, word_done_a, busy_a;
    logic [7:0]  byte_out_a;
    logic [1:0]  byte_sel_a;
    logic        word_ready_b, byte_valid_b, word_done_b, busy_b;
    logic [7:0]  byte_out_b;
    logic [1:0]  byte_sel_b;

    int errors = 0;
    int checks = 0;

    logic [31:0] q[$];
    logic [31:0] tx[$];
    int          pos;
    bit          done_exp;
    bit          cur_rn;
    bit          wacc_last;
    int          cycle;
    int          words_done;
    int          done_cycles[$];
    int          bv_cycles[$];
    logic [31:0] log_a, log_b;
    logic [7:0]  sel_log_a, sel_log_b;
    logic [31:0] asm_a, asm_b;

    // Free-running clock.
    always #5 clk = ~clk;

    data_out_encoder #(.LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready_a), .byte_out(byte_out_a), .byte_sel(byte_sel_a),
        .byte_valid(byte_valid_a), .byte_ready(byte_ready),
        .word_done(word_done_a), .busy(busy_a)
    );

    data_out_encoder #(.LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready_b), .byte_out(byte_out_b), .byte_sel(byte_sel_b),
        .byte_valid(byte_valid_b), .byte_ready(byte_ready),
        .word_done(word_done_b), .busy(busy_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    function automatic logic [1:0] laneOf(input int k, input bit lsb);
        return lsb ? 2'(k) : 2'(3 - k);
    endfunction

    function automatic logic [7:0] byteOf(input logic [31:0] w, input logic [1:0] lane);
        return w[{lane, 3'b000} +: 8];
    endfunction

    task automatic compareAll();
        bit         act;
        logic [7:0] eb_a, eb_b;
        logic [1:0] es_a, es_b;
        act  = cur_rn && (q.size() > 0);
        eb_a = 8'd0;
        eb_b = 8'd0;
        es_a = 2'd0;
        es_b = 2'd0;
        if (act) begin
            es_a = laneOf(pos, 1'b1);
            es_b = laneOf(pos, 1'b0);
            eb_a = byteOf(q[0], es_a);
            eb_b = byteOf(q[0], es_b);
        end
        checkOutput("word_ready_a", 32'(word_ready_a), 32'(cur_rn && (q.size() < 2)));
        checkOutput("word_ready_b", 32'(word_ready_b), 32'(cur_rn && (q.size() < 2)));
        checkOutput("byte_valid_a", 32'(byte_valid_a), 32'(act));
        checkOutput("byte_valid_b", 32'(byte_valid_b), 32'(act));
        checkOutput("busy_a", 32'(busy_a), 32'(act));
        checkOutput("busy_b", 32'(busy_b), 32'(act));
        checkOutput("word_done_a", 32'(word_done_a), 32'(done_exp));
        checkOutput("word_done_b", 32'(word_done_b), 32'(done_exp));
        checkOutput("byte_out_a", 32'(byte_out_a), 32'(eb_a));
        checkOutput("byte_out_b", 32'(byte_out_b), 32'(eb_b));
        if (act || !cur_rn) begin
            checkOutput("byte_sel_a", 32'(byte_sel_a), 32'(es_a));
            checkOutput("byte_sel_b", 32'(byte_sel_b), 32'(es_b));
        end
        if (byte_valid_a === 1'b1) bv_cycles.push_back(cycle);
        if (word_done_a === 1'b1) done_cycles.push_back(cycle);
    endtask

    // One clock of stimulus: check outputs, drive inputs, advance the model.
    task automatic applyStimulus(input bit rn, input bit wv, input logic [31:0] wd, input bit br);
        logic [7:0] bo_a, bo_b;
        logic [1:0] bs_a, bs_b;
        bit         wacc, bxfer;
        @(negedge clk);
        cycle++;
        compareAll();
        bo_a = byte_out_a;
        bo_b = byte_out_b;
        bs_a = byte_sel_a;
        bs_b = byte_sel_b;
        rst_n      = rn;
        word_valid = wv;
        word_in    = wd;
        byte_ready = br;
        wacc  = rn && wv && (q.size() < 2);
        bxfer = rn && br && (q.size() > 0);
        wacc_last = wacc;
        if (!rn) begin
            q.delete();
            pos      = 0;
            done_exp = 1'b0;
        end else begin
            done_exp = 1'b0;
            if (bxfer) begin
                log_a     = {log_a[23:0], bo_a};
                log_b     = {log_b[23:0], bo_b};
                sel_log_a = {sel_log_a[5:0], bs_a};
                sel_log_b = {sel_log_b[5:0], bs_b};
                asm_a[{bs_a, 3'b000} +: 8] = bo_a;
                asm_b[{bs_b, 3'b000} +: 8] = bo_b;
                pos++;
                if (pos == 4) begin
                    checkOutput("assembled_a", asm_a, q[0]);
                    checkOutput("assembled_b", asm_b, q[0]);
                    void'(q.pop_front());
                    pos      = 0;
                    done_exp = 1'b1;
                    words_done++;
                end
            end
            if (wacc) q.push_back(wd);
        end
        cur_rn = rn;
    endtask

    // Offers the words in tx until they are all sent; mode 1 uses the 1,0,0,1 byte_ready pattern.
    task automatic runTraffic(input int max_cycles, input int vprob, input int rprob, input int mode);
        int n;
        bit wv, br;
        logic [31:0] wd;
        n = 0;
        while ((tx.size() > 0 || q.size() > 0) && n < max_cycles) begin
            wv = (tx.size() > 0) && ($urandom_range(99) < 32'(vprob));
            wd = (tx.size() > 0) ? tx[0] : $urandom;
            if (mode == 1) br = ((n % 4) == 0) || ((n % 4) == 3);
            else           br = ($urandom_range(99) < 32'(rprob));
            applyStimulus(1'b1, wv, wd, br);
            if (wacc_last) void'(tx.pop_front());
            n++;
        end
        checkOutput("drain_timeout", 32'(tx.size() + q.size()), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        int base;
        rst_n      = 1'b0;
        word_valid = 1'b0;
        word_in    = 32'd0;
        byte_ready = 1'b0;
        cur_rn     = 1'b0;
        pos        = 0;
        done_exp   = 1'b0;
        cycle      = 0;
        words_done = 0;
        log_a = 0; log_b = 0; sel_log_a = 0; sel_log_b = 0; asm_a = 0; asm_b = 0;
        repeat (2) @(posedge clk);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);

        $display("[TB] single word, both lane orders");
        tx.push_back(32'hA1B2C3D4);
        runTraffic(40, 100, 100, 0);
        checkOutput("seq_bytes_lsb", log_a, 32'hD4C3B2A1);
        checkOutput("seq_bytes_msb", log_b, 32'hA1B2C3D4);
        checkOutput("seq_sel_lsb", 32'(sel_log_a), 32'h1B);
        checkOutput("seq_sel_msb", 32'(sel_log_b), 32'hE4);

        $display("[TB] back-to-back words");
        done_cycles.delete();
        bv_cycles.delete();
        tx.push_back(32'h11223344);
        tx.push_back(32'h55667788);
        runTraffic(40, 100, 100, 0);
        checkOutput("b2b_done_count", 32'(done_cycles.size()), 32'd2);
        if (done_cycles.size() >= 2)
            checkOutput("b2b_done_gap", 32'(done_cycles[1] - done_cycles[0]), 32'd4);
        checkOutput("b2b_valid_count", 32'(bv_cycles.size()), 32'd8);
        if (bv_cycles.size() > 0)
            checkOutput("b2b_valid_span", 32'(bv_cycles[bv_cycles.size() - 1] - bv_cycles[0] + 1), 32'd8);

        $display("[TB] backpressure pattern");
        base = words_done;
        tx.push_back(32'hCAFEF00D);
        tx.push_back(32'hDEADBEEF);
        runTraffic(80, 100, 100, 1);
        checkOutput("bp_words", 32'(words_done - base), 32'd2);
        checkOutput("bp_last_word", log_a, 32'hEFBEADDE);

        $display("[TB] reset mid-word with pending word");
        applyStimulus(1'b1, 1'b1, 32'h01020304, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h05060708, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        tx.push_back(32'h0BADF00D);
        runTraffic(40, 100, 100, 0);
        checkOutput("post_rst_bytes", log_a, 32'h0DF0AD0B);
        checkOutput("post_rst_sel", 32'(sel_log_a), 32'h1B);

        $display("[TB] random words with random backpressure");
        base = words_done;
        for (int i = 0; i < 200; i++) tx.push_back($urandom);
        runTraffic(20000, 70, 60, 0);
        checkOutput("rand_words", 32'(words_done - base), 32'd200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_out_encoder.md
Name: data_out_encoder

Overview:
- Transmit-side counterpart of the byte-lane word assembler.
- Accepts a 32-bit word over a valid/ready handshake and serialises it as four 8-bit bytes on a byte bus.
- Each byte carries a 2-bit lane select (byte_sel) that names its destination lane [8*sel+7 : 8*sel] in a 32-bit word register at the far end.
- A one-word pending buffer allows back-to-back words with no idle cycles on the byte bus.

Parameters:
- LSB_FIRST, 1: 1 = lanes sent in order 0,1,2,3; 0 = lanes sent in order 3,2,1,0.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- word_in  input  32  word to transmit.
- word_valid  input  1  word_in is valid.
- word_ready  output  1  encoder can accept a word this cycle.
- byte_out  output  8  current byte.
- byte_sel  output  2  lane index of byte_out.
- byte_valid  output  1  byte_out/byte_sel are valid.
- byte_ready  input  1  downstream accepts the byte this cycle.
- word_done  output  1  one-cycle pulse after the last byte of a word is accepted.
- busy  output  1  an active word or a pending word is held.

Behaviour:
- Storage and state:
  - Active register act_word[31:0], lane counter idx[1:0], state IDLE/SEND.
  - Pending register pend_word[31:0] with flag pend_valid.
- Reset (rst_n sampled low at a rising edge):
  - state=IDLE, idx=first lane, pend_valid=0, word_done=0.
  - act_word and pend_word are cleared to 0.
  - While rst_n is low: word_ready=0, byte_valid=0, busy=0, byte_out=0, byte_sel=0.
  - Reset wins over any handshake in the same cycle. Reset mid-word drops both the active and pending words with no further bytes.
- first lane = 0 if LSB_FIRST, else 3. last lane = 3 if LSB_FIRST, else 0. idx steps +1 (LSB_FIRST) or -1, and never wraps within a word.
- Outputs:
  - word_ready = rst_n & ((state==IDLE) | ~pend_valid).
  - byte_valid = (state==SEND).
  - byte_sel = idx.
  - byte_out = act_word[8*idx+7 : 8*idx] in SEND, otherwise 0.
  - busy = (state==SEND) | pend_valid.
- Handshake events:
  - Word accept (wacc) = word_valid & word_ready.
  - Byte transfer (bxfer) = byte_valid & byte_ready.
  - byte_out and byte_sel must stay stable while byte_valid=1 and byte_ready=0.
- IDLE:
  - On wacc: act_word<=word_in, idx<=first lane, state<=SEND.
  - byte_valid rises the cycle after acceptance (latency 1).
- SEND, bxfer on a non-last lane: idx advances.
- SEND, bxfer on the last lane (word complete), the next cycle has word_done=1, and:
  - if pend_valid: act_word<=pend_word, pend_valid<=0, idx<=first lane, stay SEND. If wacc occurs in the same cycle, word_in goes to pend_word and pend_valid stays 1.
  - else if wacc in the same cycle: act_word<=word_in (bypass), idx<=first lane, stay SEND.
  - else: state<=IDLE.
- SEND, no last-lane completion:
  - wacc (possible only when pend_valid=0) loads pend_word and sets pend_valid.
- word_done is registered and is 0 in every other cycle.
- Throughput: with byte_ready held at 1 and a word always offered, one byte per cycle and one word per 4 cycles, no bubbles.
- No data is ever dropped or duplicated. word_valid asserted while word_ready=0 has no effect.

Test Plan:
- After reset release, word 0xA1B2C3D4 with LSB_FIRST=1, byte_ready=1 -> cycles 1..4 after acceptance show (sel,byte) = (0,D4), (1,C3), (2,B2), (3,A1); word_done=1 in cycle 5; then IDLE, busy=0.
- Same word with LSB_FIRST=0 -> (3,A1), (2,B2), (1,C3), (0,D4).
- Back-to-back words 0x11223344 and 0x55667788, word_valid and byte_ready held at 1 -> 8 consecutive byte_valid cycles with no gap; word_ready=0 while pending is full; two word_done pulses 4 cycles apart.
- byte_ready toggled 1,0,0,1,... (backpressure) -> byte_out/byte_sel held stable during stalls; byte sequence unchanged; pending word 0xDEADBEEF accepted exactly once.
- rst_n driven low after the 2nd byte with a pending word held -> next cycle: byte_valid=0, busy=0, word_ready=0; after release, first new word starts at lane 0 with no residue.
- Receiver model (word assembler driven by byte_sel/byte_out) compared against 200 random words under random byte_ready -> every reassembled word equals the sent word.
